// File: rtl/coffee_pkg.sv
// Shared types and constants for the coffee machine sequencer: states, drink
// indices, price table, coin validation and the milk-required mask.
package coffee_pkg;

  localparam int CREDIT_W   = 5;
  localparam int NUM_DRINKS = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECTED,
    ST_CHECK,
    ST_PAY,
    ST_BREW,
    ST_ERROR
  } state_e;

  typedef enum logic [1:0] {
    ERR_WATER,
    ERR_POWDER,
    ERR_MILK,
    ERR_MONEY
  } err_e;

  localparam logic [1:0] DRINK_ESPRESSO   = 2'd0;
  localparam logic [1:0] DRINK_LATTE      = 2'd1;
  localparam logic [1:0] DRINK_CAPPUCCINO = 2'd2;
  localparam logic [1:0] DRINK_PREMIUM    = 2'd3;

  localparam logic [CREDIT_W-1:0] PRICE [NUM_DRINKS] = '{5'd1, 5'd2, 5'd5, 5'd10};

  localparam logic [NUM_DRINKS-1:0] MILK_MASK = 4'b0110;

  function automatic logic coin_valid(input logic [3:0] val);
    logic ok;
    case (val)
      4'd1, 4'd2, 4'd5, 4'd10: ok = 1'b1;
      default:                 ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Only meaningful when sel has exactly one bit set.
  function automatic logic [1:0] sel_index(input logic [3:0] sel);
    logic [1:0] idx;
    case (sel)
      4'b0010: idx = DRINK_LATTE;
      4'b0100: idx = DRINK_CAPPUCCINO;
      4'b1000: idx = DRINK_PREMIUM;
      default: idx = DRINK_ESPRESSO;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/coffee_timer.sv
// Loadable down-counter shared by the PAY timeout, BREW duration and ERROR hold.
// done_o is high while the count is zero; a load takes effect on the next edge.
module coffee_timer #(
  parameter int W = 10
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/coffee_controller.sv
// Coffee machine sequencer: selection -> ingredient check -> payment -> brew.
// All outputs are registered from the next state, so they follow an input by one edge.
module coffee_controller
  import coffee_pkg::*;
#(
  parameter int BREW_CYCLES = 250,
  parameter int PAY_TIMEOUT = 1000,
  parameter int ERR_HOLD    = 500
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] BTN_SEL,
  input  logic       BTN_OK,
  input  logic       BTN_CANCEL,
  input  logic       COIN_IN,
  input  logic [3:0] COIN_VAL,
  input  logic       LVL_WATER,
  input  logic       LVL_POWDER,
  input  logic       LVL_MILK,
  output logic       S0,
  output logic       S1,
  output logic       S2,
  output logic       S3,
  output logic       SR,
  output logic       SP,
  output logic       SN,
  output logic       VL,
  output logic       M,
  output logic       BREW,
  output logic       RET_VALID,
  output logic [4:0] RET_VALUE
);

  localparam int TMR_MAX = (PAY_TIMEOUT > BREW_CYCLES) ?
                           ((PAY_TIMEOUT > ERR_HOLD) ? PAY_TIMEOUT : ERR_HOLD) :
                           ((BREW_CYCLES > ERR_HOLD) ? BREW_CYCLES : ERR_HOLD);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  state_e              state_q, state_d;
  logic [1:0]          drink_q, drink_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  err_e                err_q, err_d;
  logic                ret_vld_q, ret_vld_d;
  logic [4:0]          ret_val_q, ret_val_d;
  logic [3:0]          sel_q;
  logic [3:0]          flag_q;
  logic                m_q, brew_q;

  logic                tmr_load;
  logic [TMR_W-1:0]    tmr_val;
  logic                tmr_done;

  logic [CREDIT_W:0]   sum_raw;
  logic [CREDIT_W-1:0] credit_sum;
  logic [CREDIT_W-1:0] price;
  logic                coin_ok;

  coffee_timer #(.W(TMR_W)) u_timer (
    .clk_i      (CLK),
    .rst_ni     (RST),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  assign sum_raw    = {1'b0, credit_q} + {2'b00, COIN_VAL};
  assign credit_sum = (sum_raw > 6'd31) ? 5'd31 : sum_raw[CREDIT_W-1:0];
  assign price      = PRICE[drink_q];
  assign coin_ok    = coin_valid(COIN_VAL);

  always_comb begin
    state_d   = state_q;
    drink_d   = drink_q;
    credit_d  = credit_q;
    err_d     = err_q;
    ret_vld_d = 1'b0;
    ret_val_d = ret_val_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;

    case (state_q)
      ST_IDLE: begin
        if ($onehot(BTN_SEL)) begin
          drink_d = sel_index(BTN_SEL);
          state_d = ST_SELECTED;
        end
      end

      ST_SELECTED: begin
        if (BTN_CANCEL) begin
          state_d = ST_IDLE;
        end else if (BTN_OK) begin
          state_d = ST_CHECK;
        end else if ($onehot(BTN_SEL)) begin
          drink_d = sel_index(BTN_SEL);
        end
      end

      ST_CHECK: begin
        if (!LVL_WATER) begin
          err_d = ERR_WATER;
        end else if (!LVL_POWDER) begin
          err_d = ERR_POWDER;
        end else if (MILK_MASK[drink_q] && !LVL_MILK) begin
          err_d = ERR_MILK;
        end
        if (!LVL_WATER || !LVL_POWDER || (MILK_MASK[drink_q] && !LVL_MILK)) begin
          state_d  = ST_ERROR;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(ERR_HOLD - 1);
        end else begin
          state_d  = ST_PAY;
          credit_d = '0;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(PAY_TIMEOUT);
        end
      end

      ST_PAY: begin
        // Cancel outranks a same-cycle coin, but a valid coin is still refunded.
        if (BTN_CANCEL) begin
          state_d   = ST_IDLE;
          ret_vld_d = 1'b1;
          ret_val_d = (COIN_IN && coin_ok) ? credit_sum : credit_q;
          credit_d  = '0;
        end else if (COIN_IN && !coin_ok) begin
          state_d   = ST_ERROR;
          err_d     = ERR_MONEY;
          ret_vld_d = 1'b1;
          ret_val_d = credit_q;
          credit_d  = '0;
          tmr_load  = 1'b1;
          tmr_val   = TMR_W'(ERR_HOLD - 1);
        end else if (COIN_IN) begin
          if (credit_sum >= price) begin
            state_d   = ST_BREW;
            ret_vld_d = 1'b1;
            ret_val_d = credit_sum - price;
            credit_d  = '0;
            tmr_load  = 1'b1;
            tmr_val   = TMR_W'(BREW_CYCLES - 1);
          end else begin
            credit_d = credit_sum;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(PAY_TIMEOUT);
          end
        end else if (tmr_done) begin
          state_d   = ST_ERROR;
          err_d     = ERR_MONEY;
          ret_vld_d = 1'b1;
          ret_val_d = credit_q;
          credit_d  = '0;
          tmr_load  = 1'b1;
          tmr_val   = TMR_W'(ERR_HOLD - 1);
        end
      end

      ST_BREW: begin
        if (tmr_done) begin
          state_d = ST_IDLE;
        end
      end

      ST_ERROR: begin
        if (BTN_CANCEL || tmr_done) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      drink_q   <= DRINK_ESPRESSO;
      credit_q  <= '0;
      err_q     <= ERR_WATER;
      ret_vld_q <= 1'b0;
      ret_val_q <= '0;
      sel_q     <= '0;
      flag_q    <= '0;
      m_q       <= 1'b1;
      brew_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      drink_q   <= drink_d;
      credit_q  <= credit_d;
      err_q     <= err_d;
      ret_vld_q <= ret_vld_d;
      ret_val_q <= ret_val_d;
      sel_q     <= (state_d inside {ST_SELECTED, ST_CHECK, ST_PAY, ST_BREW}) ?
                   (4'b0001 << drink_d) : 4'b0000;
      // flag_q bit order: {SR, SP, SN, VL}
      flag_q    <= (state_d == ST_ERROR) ? (4'b1000 >> err_d) : 4'b0000;
      m_q       <= (state_d == ST_IDLE);
      brew_q    <= (state_d == ST_BREW);
    end
  end

  assign {S3, S2, S1, S0}   = sel_q;
  assign {SR, SP, SN, VL}   = flag_q;
  assign M                  = m_q;
  assign BREW               = brew_q;
  assign RET_VALID          = ret_vld_q;
  assign RET_VALUE          = ret_val_q;

endmodule

// File: doc/coffee_controller.md
# coffee_controller

Central sequencing FSM of the coffee machine, directly upstream of the display decoder. It takes debounced front-panel buttons, coin pulses and ingredient-level sensors, and runs selection → ingredient check → payment → brew. It drives the one-hot drink indicators S0–S3, error flags SR/SP/SN/VL and standby flag M that the display decoder turns into CE01/CL02/CC05/CP10, ERSR/ERSP/ERSN/ERDI or the wait pattern. It also drives the brew actuator and coin return.

## Interface
- BREW_CYCLES, 250, cycles BREW stays high
- PAY_TIMEOUT, 1000, idle cycles allowed in PAY before a VL error
- ERR_HOLD, 500, cycles an error flag is held
- CLK  input  1  system clock, all logic on rising edge
- RST  input  1  reset, asynchronous and active-low
- BTN_SEL  input  4  drink select pulses (bit0 espresso, bit1 latte, bit2 cappuccino, bit3 premium), one cycle wide, already synchronised
- BTN_OK  input  1  confirm pulse
- BTN_CANCEL  input  1  cancel/acknowledge pulse
- COIN_IN  input  1  coin-accepted strobe
- COIN_VAL  input  4  coin value in units, sampled when COIN_IN=1
- LVL_WATER, LVL_POWDER, LVL_MILK  input  1 each  level sensors, 1 = sufficient
- S0, S1, S2, S3  output  1 each  selected drink, one-hot or all zero
- SR, SP, SN  output  1 each  water / powder / milk error flags
- VL  output  1  money error flag
- M  output  1  standby (IDLE) flag
- BREW  output  1  brew actuator enable
- RET_VALID  output  1  one-cycle strobe: return RET_VALUE units
- RET_VALUE  output  5  change or refund amount

## Operation
- States: IDLE, SELECTED, CHECK, PAY, BREW, ERROR.
- Prices are 1, 2, 5 and 10 units for drinks 0–3. Valid coins are 1, 2, 5 and 10.
- All outputs are registered. Only the flag belonging to the current state is high. Error flags are mutually exclusive.
- **IDLE**: M=1. A BTN_SEL with exactly one bit set latches that drink and moves to SELECTED. Zero bits or multiple bits are ignored.
- **SELECTED**: the matching S bit is high.
  - A new single-bit BTN_SEL reselects.
  - BTN_CANCEL goes to IDLE.
  - BTN_OK goes to CHECK.
  - If BTN_OK and BTN_CANCEL arrive together, CANCEL wins.
- **CHECK** (exactly 1 cycle): checks sensors in priority water > powder > milk.
  - Milk is required only for drinks 1 and 2.
  - On the first failure, go to ERROR with SR, SP or SN set.
  - If all pass, go to PAY with credit cleared to 0.
- **PAY**: S bit stays high. Credit is 5 bits, saturating at 31.
  - A valid coin adds to credit and reloads the timeout.
  - If credit+coin ≥ price, go to BREW; RET_VALUE = credit+coin−price, with RET_VALID pulsed on BREW entry.
  - An invalid COIN_VAL goes to ERROR with VL set, refunding the credit.
  - Timeout expiry goes to ERROR with VL set, refunding the credit.
  - BTN_CANCEL refunds credit (plus any same-cycle valid coin) and returns to IDLE.
  - A refund of 0 still pulses RET_VALID with RET_VALUE=0.
- **BREW**: BREW=1 and the S bit is held. BTN_CANCEL, BTN_SEL and coins are ignored. Exit to IDLE after BREW_CYCLES.
- **ERROR**: the flag is held for ERR_HOLD cycles, then the FSM returns to IDLE. BTN_CANCEL returns to IDLE early. S bits are 0.

## Timing
- Reset (async assert, sync release):
  - state IDLE, M=1, credit 0, timer 0.
  - S0–S3, SR, SP, SN, VL, BREW, RET_VALID = 0; RET_VALUE = 0.
- Button pulse at edge n → outputs change at edge n+1.
- OK at n → CHECK at n+1 → PAY or ERROR at n+2.
- Coin at n reaching price → BREW=1 and RET_VALID=1 at n+1. BREW stays high exactly BREW_CYCLES cycles.
- PAY timeout: VL rises PAY_TIMEOUT+1 cycles after PAY entry or after the last coin.
- RET_VALID is always a single-cycle strobe. RET_VALUE holds its value until the next strobe.
- Reset mid-BREW or mid-PAY drops BREW immediately. No refund strobe is issued and credit is lost (accepted behaviour).

## Structure
- coffee_pkg holds:
  - state enum
  - drink index constants
  - PRICE array (1, 2, 5, 10)
  - coin-valid function
  - credit width (5)
  - milk-required mask (4'b0110)
- Sub-module coffee_timer is a loadable down-counter with a `done` output. It is shared by PAY timeout, BREW duration and ERR hold, since those states are mutually exclusive. The FSM loads it on state entry.

## Test plan
- Reset, then BTN_SEL=4'b0001, OK, coin 1 → S0 high; BREW high 250 cycles; RET_VALID with 0; then M=1.
- Select bit2, LVL_MILK=0, OK → SN=1, S2=0 for 500 cycles, then IDLE; with CANCEL mid-hold → IDLE next cycle.
- Select bit3, coins 5 then 10 → BREW, RET_VALUE=5; coin 2 in PAY then timeout → VL=1 and RET_VALUE=2.
- In PAY, COIN_VAL=3 → VL=1 and credit refunded; same-cycle CANCEL+coin 2 with credit 1 → IDLE, RET_VALUE=3.
- BTN_SEL=4'b0110 in IDLE → no change; LVL_WATER=0 and LVL_POWDER=0 → SR only.
- Assert RST mid-BREW → BREW=0 and M=1 asynchronously; no RET_VALID.
